// File: rtl/gate_truth_sequencer.sv
// Drives a 2-input gate under test through 00,01,10,11, holds each vector
// HOLD_CYCLES cycles, samples y and scores it against the selected function.
module gate_truth_sequencer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int            CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_op;
  logic [1:0]    r_vec;
  logic [CW-1:0] r_hold;
  logic [2:0]    r_err;
  logic [3:0]    r_fail;
  logic          r_pass;

  logic          w_start_ok;
  logic          w_sample;
  logic          w_last;
  logic          w_expected;
  logic          w_mismatch;
  logic [3:0]    w_fail_next;
  logic [2:0]    w_err_next;

  assign w_start_ok = start && (r_state != S_RUN);
  assign w_sample   = (r_state == S_RUN) && (r_hold == HOLD_LAST);
  assign w_last     = w_sample && (r_vec == 2'd3);

  // The vector index doubles as the driven {a,b} pair.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    w_expected = 1'b0;
    unique case (r_op)
      3'b000:  w_expected =   r_vec[1] & r_vec[0];
      3'b001:  w_expected =   r_vec[1] | r_vec[0];
      3'b010:  w_expected = ~(r_vec[1] & r_vec[0]);
      3'b011:  w_expected = ~(r_vec[1] | r_vec[0]);
      3'b100:  w_expected =   r_vec[1] ^ r_vec[0];
      3'b101:  w_expected = ~(r_vec[1] ^ r_vec[0]);
      3'b110:  w_expected =   r_vec[1];
      default: w_expected =  ~r_vec[1];
    endcase
  end

  // Case inequality so an X or Z on y is scored as a mismatch in simulation.
  assign w_mismatch  = (y !== w_expected);
  assign w_fail_next = r_fail | ({3'b000, w_mismatch} << r_vec);
  assign w_err_next  = r_err + {2'b00, w_mismatch};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  if (start)  w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= 3'b000;
      r_vec  <= 2'b00;
      r_hold <= '0;
      r_err  <= 3'b000;
      r_fail <= 4'b0000;
      r_pass <= 1'b0;
    end else if (w_start_ok) begin
      r_op   <= op;
      r_vec  <= 2'b00;
      r_hold <= '0;
      r_err  <= 3'b000;
      r_fail <= 4'b0000;
      r_pass <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_sample) begin
        r_hold <= '0;
        r_fail <= w_fail_next;
        r_err  <= w_err_next;
        if (w_last) begin
          r_vec  <= 2'b00;
          r_pass <= (w_fail_next == 4'b0000);
        end else begin
          r_vec  <= r_vec + 2'd1;
        end
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign a         = r_vec[1];
  assign b         = r_vec[0];
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Scoreboard bench: stimulus pushes expected run results, per-DUT monitors
// pop them when a run finishes and also track the {a,b} stepping.
module tb_gate_truth_sequencer;

  typedef enum int {G_OR, G_ONE, G_XOR} gate_t;
  typedef struct {
    int         len;
    logic       pass;
    logic [2:0] err;
    logic [3:0] fail;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, start4, y4, a4, b4, busy4, done4, pass4;
  logic [2:0] op4, err4;
  logic [3:0] fail4;
  gate_t      gate4;

  logic       rst1, start1, y1, a1, b1, busy1, done1, pass1;
  logic [2:0] op1, err1;
  logic [3:0] fail1;
  gate_t      gate1;

  int   total = 0;
  int   bad   = 0;
  exp_t q4[$];
  exp_t q1[$];

  gate_truth_sequencer #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .op(op4), .y(y4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .fail_vec(fail4)
  );

  gate_truth_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .op(op1), .y(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1)
  );

  function automatic logic gate_out(input gate_t g, input logic ga, input logic gb);
    case (g)
      G_OR:    return ga | gb;
      G_ONE:   return 1'b1;
      default: return ga ^ gb;
    endcase
  endfunction

  always_comb y4 = gate_out(gate4, a4, b4);
  always_comb y1 = gate_out(gate1, a1, b1);

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the HOLD_CYCLES=4 instance.
  int   cnt4 = 0;
  logic pb4  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy4 === 1'b1) begin
      check("vec4", int'({a4, b4}), cnt4 / 4);
      cnt4++;
    end else begin
      if (pb4 === 1'b1 && done4 === 1'b1) begin
        if (q4.size() == 0) begin
          check("unexpected_run4", 1, 0);
        end else begin
          e = q4.pop_front();
          check("len4",  cnt4, e.len);
          check("pass4", int'(pass4), int'(e.pass));
          check("err4",  int'(err4),  int'(e.err));
          check("fail4", int'(fail4), int'(e.fail));
          check("ab_done4", int'({a4, b4}), 0);
        end
      end
      cnt4 = 0;
    end
    pb4 = busy4;
  end

  // Monitor for the HOLD_CYCLES=1 instance.
  int   cnt1 = 0;
  logic pb1  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy1 === 1'b1) begin
      check("vec1", int'({a1, b1}), cnt1);
      cnt1++;
    end else begin
      if (pb1 === 1'b1 && done1 === 1'b1) begin
        if (q1.size() == 0) begin
          check("unexpected_run1", 1, 0);
        end else begin
          e = q1.pop_front();
          check("len1",  cnt1, e.len);
          check("pass1", int'(pass1), int'(e.pass));
          check("err1",  int'(err1),  int'(e.err));
          check("fail1", int'(fail1), int'(e.fail));
        end
      end
      cnt1 = 0;
    end
    pb1 = busy1;
  end

  function automatic exp_t mk_exp(input int len, input logic [3:0] f, input int e);
    exp_t x;
    x.len  = len;
    x.fail = f;
    x.err  = 3'(e);
    x.pass = (f == 4'b0000);
    return x;
  endfunction

  task automatic wait_q4();
    int n = 0;
    while (q4.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0) begin
      check("timeout4", q4.size(), 0);
      q4.delete();
    end
  endtask

  task automatic wait_q1();
    int n = 0;
    while (q1.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0) begin
      check("timeout1", q1.size(), 0);
      q1.delete();
    end
  endtask

  task automatic run4(input logic [2:0] op, input gate_t g, input logic [3:0] f, input int e);
    @(negedge clk);
    gate4  = g;
    op4    = op;
    start4 = 1'b1;
    q4.push_back(mk_exp(16, f, e));
    @(negedge clk);
    start4 = 1'b0;
    check("done_clr4", int'(done4), 0);
    wait_q4();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst4 = 1'b1; start4 = 1'b0; op4 = 3'b000; gate4 = G_OR;
    rst1 = 1'b1; start1 = 1'b0; op1 = 3'b000; gate1 = G_XOR;
    repeat (3) @(negedge clk);
    check("rst_busy4", int'(busy4), 0);
    check("rst_done4", int'(done4), 0);
    check("rst_pass4", int'(pass4), 0);
    check("rst_err4",  int'(err4),  0);
    check("rst_fail4", int'(fail4), 0);
    check("rst_ab4",   int'({a4, b4}), 0);
    check("rst_busy1", int'(busy1), 0);
    check("rst_done1", int'(done1), 0);
    rst4 = 1'b0;
    rst1 = 1'b0;

    run4(3'b001, G_OR,  4'b0000, 0);
    run4(3'b000, G_OR,  4'b0110, 2);
    run4(3'b011, G_ONE, 4'b1110, 3);
    run4(3'b011, G_OR,  4'b1111, 4);
    run4(3'b111, G_ONE, 4'b1100, 2);
    run4(3'b010, G_XOR, 4'b0001, 1);

    // start re-pulsed and op changed mid-run: original OR result must stand
    @(negedge clk);
    gate4 = G_OR; op4 = 3'b001; start4 = 1'b1;
    q4.push_back(mk_exp(16, 4'b0000, 0));
    @(negedge clk);
    start4 = 1'b0;
    repeat (5) @(negedge clk);
    start4 = 1'b1; op4 = 3'b000;
    @(negedge clk);
    start4 = 1'b0;
    wait_q4();

    // reset during vector 2 after vector 1 already mismatched
    @(negedge clk);
    gate4 = G_OR; op4 = 3'b000; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while ({a4, b4} != 2'b10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_vec2", int'({a4, b4}), 2);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    check("abort_busy4", int'(busy4), 0);
    check("abort_done4", int'(done4), 0);
    check("abort_pass4", int'(pass4), 0);
    check("abort_err4",  int'(err4),  0);
    check("abort_fail4", int'(fail4), 0);
    check("abort_ab4",   int'({a4, b4}), 0);
    run4(3'b001, G_OR, 4'b0000, 0);

    // HOLD_CYCLES=1, XOR gate, start held high for back-to-back runs
    @(negedge clk);
    gate1 = G_XOR; op1 = 3'b100; start1 = 1'b1;
    q1.push_back(mk_exp(4, 4'b0000, 0));
    q1.push_back(mk_exp(4, 4'b0000, 0));
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 start1 = 1'b0;
    wait_q1();

    // XOR gate scored as XNOR: every vector mismatches
    @(negedge clk);
    op1 = 3'b101; start1 = 1'b1;
    q1.push_back(mk_exp(4, 4'b1111, 4));
    @(negedge clk);
    start1 = 1'b0;
    wait_q1();

    repeat (3) @(negedge clk);
    check("q4_empty", q4.size(), 0);
    check("q1_empty", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
